neureka_output_packer: RTL

- Sits directly downstream of the normalization/quantization stage.
- Accepts one quantized beat per handshake: NMULT lanes of 32 bits, interpreted according to the per-beat mode.
- Extracts exactly 4 valid bytes per beat and packs them into OUT_W-bit output words.
- Drives the words onto a valid/ready stream towards the output streamer, with byte strobes and a last flag.
- Holds one packing register and one output register, so packing continues while the output is stalled.

---
 rtl/neureka_output_packer_pkg.sv | 18 +
 rtl/neureka_packer_byte_extract.sv | 30 +++
 rtl/neureka_output_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/neureka_output_packer_pkg.sv
// Shared constants and types for the NEUREKA output packer.
//   NEUREKA_MODE_8B/16B/32B : per-beat quantization mode encodings
//   NEUREKA_PACKER_OUT_W    : default packed output word width in bits
//   neureka_packer_state_t  : packer sequencing states
package neureka_package;

    localparam logic [1:0] NEUREKA_MODE_8B  = 2'd0;
    localparam logic [1:0] NEUREKA_MODE_16B = 2'd1;
    localparam logic [1:0] NEUREKA_MODE_32B = 2'd2;

    localparam int unsigned NEUREKA_PACKER_OUT_W = 256;

    typedef enum logic {
        PACK_FILL,
        PACK_WAIT
    } neureka_packer_state_t;

endpackage

// File: rtl/neureka_packer_byte_extract.sv
// Combinational selection of the 4 valid bytes of one quantized beat.
// Ports:
//   mode_i  : beat mode (NEUREKA_MODE_8B/16B/32B)
//   data_i  : NMULT lanes of 32 bits
//   bytes_o : extracted bytes {b3, b2, b1, b0}
module neureka_packer_byte_extract
    import neureka_package::*;
#(
    parameter int unsigned NMULT = 4
) (
    input  logic [1:0]          mode_i,
    input  logic [NMULT*32-1:0] data_i,
    output logic [31:0]         bytes_o
);

    // Lane bits that no mode ever selects.
    logic unused_lanes;
    assign unused_lanes = ^{data_i[127:104], data_i[95:72], data_i[63:48]};

    always_comb begin
        // 8B: low byte of each lane; the unused mode encoding also lands here.
        bytes_o = {data_i[103:96], data_i[71:64], data_i[39:32], data_i[7:0]};
        case (mode_i)
            NEUREKA_MODE_16B: bytes_o = {data_i[47:32], data_i[15:0]};
            NEUREKA_MODE_32B: bytes_o = data_i[31:0];
            default:          ;
        endcase
    end

endmodule

// File: rtl/neureka_output_packer.sv
// Packs 4 extracted bytes per input beat into OUT_W-bit words with strobes and last.
// One packing register plus one output register so filling continues under backpressure.
// Optional macro NEUREKA_OUTPUT_PACKER_PERF_EN enables the output-stall counter.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   test_mode_i            : no functional effect
//   clear_i                : synchronous clear, highest priority
//   mode_i                 : beat mode, sampled per accepted beat
//   in_valid_i/in_ready_o  : input beat handshake; in_data_i lanes, in_last_i flushes word
//   out_valid_o/out_ready_i: output word handshake; out_data_o, out_strb_o, out_last_o
//   perf_stall_o           : cycles with out_valid_o && !out_ready_i (0 when disabled)
module neureka_output_packer
    import neureka_package::*;
#(
    parameter int unsigned NMULT = 4,
    parameter int unsigned OUT_W = NEUREKA_PACKER_OUT_W,
    parameter int unsigned BEATS = OUT_W / 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 clear_i,
    input  logic [1:0]           mode_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NMULT*32-1:0]  in_data_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_W-1:0]     out_data_o,
    output logic [OUT_W/8-1:0]   out_strb_o,
    output logic                 out_last_o,
    output logic [31:0]          perf_stall_o
);

    localparam int unsigned STRB_W = OUT_W / 8;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    neureka_packer_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  pack_data_q, pack_data_d;
    logic [STRB_W-1:0] pack_strb_q, pack_strb_d;
    logic              pack_last_q, pack_last_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [STRB_W-1:0] out_strb_q, out_strb_d;
    logic              out_last_q, out_last_d;

    logic [31:0]       beat_bytes;
    logic [OUT_W-1:0]  merged_data;
    logic [STRB_W-1:0] merged_strb;
    logic              accept, complete, slot_free;

    logic unused_test;
    assign unused_test = test_mode_i;

    neureka_packer_byte_extract #(
        .NMULT(NMULT)
    ) u_extract (
        .mode_i (mode_i),
        .data_i (in_data_i),
        .bytes_o(beat_bytes)
    );

    // Beat n lands at bytes 4n..4n+3; unwritten bytes stay zero because the pack
    // register is cleared whenever a word leaves it.
    assign merged_data = pack_data_q | (OUT_W'(beat_bytes) << {cnt_q, 5'b00000});
    assign merged_strb = pack_strb_q | (STRB_W'(4'hF) << {cnt_q, 2'b00});

    assign in_ready_o = (state_q == PACK_FILL);
    assign accept     = in_valid_i && in_ready_o;
    assign complete   = (cnt_q == CNT_W'(BEATS - 1)) || in_last_i;
    assign slot_free  = !out_valid_q || out_ready_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pack_data_d = pack_data_q;
        pack_strb_d = pack_strb_q;
        pack_last_d = pack_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            PACK_FILL: begin
                if (accept) begin
                    if (!complete) begin
                        pack_data_d = merged_data;
                        pack_strb_d = merged_strb;
                        cnt_d       = cnt_q + CNT_W'(1);
                    end else if (slot_free) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged_data;
                        out_strb_d  = merged_strb;
                        out_last_d  = in_last_i;
                        pack_data_d = '0;
                        pack_strb_d = '0;
                        pack_last_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        // Park the finished word until the output slot opens.
                        pack_data_d = merged_data;
                        pack_strb_d = merged_strb;
                        pack_last_d = in_last_i;
                        state_d     = PACK_WAIT;
                    end
                end
            end
            PACK_WAIT: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pack_data_q;
                    out_strb_d  = pack_strb_q;
                    out_last_d  = pack_last_q;
                    pack_data_d = '0;
                    pack_strb_d = '0;
                    pack_last_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = PACK_FILL;
                end
            end
            default: state_d = PACK_FILL;
        endcase

        if (clear_i) begin
            state_d     = PACK_FILL;
            cnt_d       = '0;
            pack_data_d = '0;
            pack_strb_d = '0;
            pack_last_d = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_strb_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= PACK_FILL;
            cnt_q       <= '0;
            pack_data_q <= '0;
            pack_strb_q <= '0;
            pack_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pack_data_q <= pack_data_d;
            pack_strb_q <= pack_strb_d;
            pack_last_q <= pack_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;

`ifdef NEUREKA_OUTPUT_PACKER_PERF_EN
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q <= '0;
        end else if (clear_i) begin
            perf_stall_q <= '0;
        end else if (out_valid_q && !out_ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_stall_o = perf_stall_q;
`else
    assign perf_stall_o = '0;
`endif

endmodule
